// File: rtl/bike_light_if.sv
// Purpose : groups the light controller's front-panel pulses and its
//           light/status outputs into one bundle.
// Signals : next, up, down  one-cycle pulses from the button front end
//           leds            NUM_LEDS light outputs
//           mode            current mode (0=OFF 1=ON 2=BLINK 3=CHASE)
//           speed_div       current blink/chase speed divisor
// Modports: master drives the pulses and observes the outputs,
//           slave is the controller side.
// Handshake: there is no valid/ready pair. Each pulse is a single-cycle
//           strobe sampled on the rising clock edge. The outputs are levels
//           that are valid in every cycle.
interface bike_light_if #(
  parameter int NUM_LEDS = 8,
  parameter int DIV_W    = 4
);
  logic                next;
  logic                up;
  logic                down;
  logic [NUM_LEDS-1:0] leds;
  logic [1:0]          mode;
  logic [DIV_W-1:0]    speed_div;

  modport master (output next, up, down, input leds, mode, speed_div);
  modport slave  (input next, up, down, output leds, mode, speed_div);
endinterface

// File: rtl/bike_light_ctrl.sv
// Purpose : multi-LED rear bicycle light controller with four modes:
//           OFF, ON, BLINK and CHASE. In CHASE a single lit LED bounces
//           from end to end. The blink/chase rate is one step every
//           TICK_CYCLES*speed_div clock cycles. The divisor saturates in
//           the range 1..DIV_MAX.
// Ports   : clk    system clock, rising edge
//           reset  asynchronous, active-high
//           bus    bike_light_if.slave (next/up/down in; leds/mode/speed_div out)
// The mode register is the FSM state and is visible on bus.mode.
module bike_light_ctrl #(
  parameter int NUM_LEDS    = 8,
  parameter int TICK_CYCLES = 2500000,
  parameter int DIV_MAX     = 8,
  parameter int DIV_INIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  bike_light_if.slave bus
);
  localparam int DIV_W  = $clog2(DIV_MAX + 1);
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int POS_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_CHASE = 2'd3;

  logic [1:0]        r_mode;
  logic [DIV_W-1:0]  r_speed_div;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [DIV_W-1:0]  r_step_cnt;
  logic              r_phase;
  logic [POS_W-1:0]  r_pos;
  logic              r_dir_up;

  logic              w_tick;
  logic              w_step;
  logic              w_faster;
  logic              w_slower;
  logic              w_clr;
  logic [NUM_LEDS-1:0] w_onehot;
  logic [NUM_LEDS-1:0] w_leds;

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign w_step = w_tick && (r_step_cnt == r_speed_div - DIV_W'(1));

  // A press that would hit a saturation limit is ignored. Such a press
  // leaves the timing counters running.
  assign w_faster = bus.up && !bus.down && (r_speed_div != DIV_W'(1));
  assign w_slower = bus.down && !bus.up && (r_speed_div != DIV_W'(DIV_MAX));

  // Any mode change or effective speed change restarts the step timing,
  // so the next step is a full new period away.
  assign w_clr = bus.next || w_faster || w_slower;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_step_cnt <= '0;
    end else if (w_clr) begin
      r_tick_cnt <= '0;
      r_step_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_step)
        r_step_cnt <= '0;
      else if (w_tick)
        r_step_cnt <= r_step_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_speed_div <= DIV_W'(DIV_INIT);
    else if (w_faster)
      r_speed_div <= r_speed_div - DIV_W'(1);
    else if (w_slower)
      r_speed_div <= r_speed_div + DIV_W'(1);
  end

  // Mode FSM: OFF -> ON -> BLINK -> CHASE -> OFF. The 2-bit wrap gives the cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_mode <= MODE_OFF;
    else if (bus.next)
      r_mode <= r_mode + 2'd1;
  end

  // The blink phase runs in every mode. It only becomes visible in BLINK,
  // and entering BLINK forces it back to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_phase <= 1'b1;
    else if (bus.next)
      r_phase <= 1'b1;
    else if (w_step)
      r_phase <= ~r_phase;
  end

  // Bounce: the direction flips while leaving an end. This keeps each
  // end LED lit for exactly one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos    <= '0;
      r_dir_up <= 1'b1;
    end else if (bus.next) begin
      r_pos    <= '0;
      r_dir_up <= 1'b1;
    end else if (w_step && r_mode == MODE_CHASE && NUM_LEDS > 1) begin
      if (r_dir_up) begin
        if (r_pos == POS_W'(NUM_LEDS - 1)) begin
          r_dir_up <= 1'b0;
          r_pos    <= r_pos - POS_W'(1);
        end else begin
          r_pos <= r_pos + POS_W'(1);
        end
      end else begin
        if (r_pos == '0) begin
          r_dir_up <= 1'b1;
          r_pos    <= r_pos + POS_W'(1);
        end else begin
          r_pos <= r_pos - POS_W'(1);
        end
      end
    end
  end

  assign w_onehot = NUM_LEDS'(1) << r_pos;

  always_comb begin
    w_leds = '0;
    case (r_mode)
      MODE_OFF:   w_leds = '0;
      MODE_ON:    w_leds = '1;
      MODE_BLINK: w_leds = {NUM_LEDS{r_phase}};
      MODE_CHASE: w_leds = w_onehot;
      default:    w_leds = '0;
    endcase
  end

  assign bus.leds      = w_leds;
  assign bus.mode      = r_mode;
  assign bus.speed_div = r_speed_div;
endmodule

// File: tb/tb_bike_light_ctrl.sv
// Bench for bike_light_ctrl using NUM_LEDS=4, TICK_CYCLES=4, DIV_MAX=4 and
// DIV_INIT=2.
// The reference model tracks the mode, the divisor, the edges since the last
// timing restart, and the number of steps since mode entry. The LED pattern
// is derived from these values arithmetically.
module tb_bike_light_ctrl;
  localparam int NUM_LEDS    = 4;
  localparam int TICK_CYCLES = 4;
  localparam int DIV_MAX     = 4;
  localparam int DIV_INIT    = 2;
  localparam int DIV_W       = $clog2(DIV_MAX + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bike_light_if #(.NUM_LEDS(NUM_LEDS), .DIV_W(DIV_W)) bus ();

  bike_light_ctrl #(
    .NUM_LEDS(NUM_LEDS), .TICK_CYCLES(TICK_CYCLES),
    .DIV_MAX(DIV_MAX), .DIV_INIT(DIV_INIT)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode   = 0;
  int m_div    = DIV_INIT;
  int m_e      = 0;   // edges since the last timing restart
  int m_nsteps = 0;   // steps since mode entry

  function automatic int bounce_pos(input int n);
    int per, r;
    if (NUM_LEDS == 1) return 0;
    per = 2 * (NUM_LEDS - 1);
    r = n % per;
    return (r < NUM_LEDS) ? r : per - r;
  endfunction

  function automatic int exp_leds(input int mode, input int nsteps);
    int all_on;
    all_on = (1 << NUM_LEDS) - 1;
    case (mode)
      0: return 0;
      1: return all_on;
      2: return (nsteps % 2 == 0) ? all_on : 0;
      default: return 1 << bounce_pos(nsteps);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode   <= 0;
      m_div    <= DIV_INIT;
      m_e      <= 0;
      m_nsteps <= 0;
    end else begin : model_edge
      int nd;
      bit stepped;
      stepped = ((m_e + 1) % (TICK_CYCLES * m_div)) == 0;
      nd = m_div;
      if (bus.up && !bus.down && m_div > 1) nd = m_div - 1;
      if (bus.down && !bus.up && m_div < DIV_MAX) nd = m_div + 1;
      m_div <= nd;
      if (bus.next) begin
        m_mode   <= (m_mode + 1) % 4;
        m_nsteps <= 0;
      end else if (stepped) begin
        m_nsteps <= m_nsteps + 1;
      end
      m_e <= (bus.next || nd != m_div) ? 0 : m_e + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cyc_leds", 32'(bus.leds), 32'(exp_leds(m_mode, m_nsteps)));
    chk("cyc_mode", 32'(bus.mode), 32'(m_mode));
    chk("cyc_div",  32'(bus.speed_div), 32'(m_div));
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic n, input logic u, input logic d);
    bus.next = n;
    bus.up   = u;
    bus.down = d;
    @(posedge clk);
    #1;
    bus.next = 1'b0;
    bus.up   = 1'b0;
    bus.down = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] chase_seq [7];

  initial begin
    chase_seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    bus.next = 1'b0;
    bus.up   = 1'b0;
    bus.down = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_leds", 32'(bus.leds), 32'h0);
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_div",  32'(bus.speed_div), 32'd2);

    // OFF -> ON -> BLINK
    pulse(1, 0, 0);
    chk("on_leds", 32'(bus.leds), 32'hF);
    chk("on_mode", 32'(bus.mode), 32'd1);
    pulse(1, 0, 0);
    chk("blink_entry_leds", 32'(bus.leds), 32'hF);
    chk("blink_entry_mode", 32'(bus.mode), 32'd2);
    wait_cycles(7);
    chk("blink_pre_toggle", 32'(bus.leds), 32'hF);
    wait_cycles(1);
    chk("blink_toggle_8", 32'(bus.leds), 32'h0);
    wait_cycles(8);
    chk("blink_toggle_16", 32'(bus.leds), 32'hF);

    // Speed-up press 5 cycles after a toggle restarts the period.
    wait_cycles(4);
    pulse(0, 1, 0);
    chk("blink_up_div", 32'(bus.speed_div), 32'd1);
    wait_cycles(3);
    chk("blink_after_up_3", 32'(bus.leds), 32'hF);
    wait_cycles(1);
    chk("blink_after_up_4", 32'(bus.leds), 32'h0);
    wait_cycles(4);
    chk("blink_after_up_8", 32'(bus.leds), 32'hF);
    pulse(0, 0, 1);
    chk("blink_down_div", 32'(bus.speed_div), 32'd2);

    // CHASE bounce
    pulse(1, 0, 0);
    chk("chase_entry_leds", 32'(bus.leds), 32'h1);
    chk("chase_entry_mode", 32'(bus.mode), 32'd3);
    for (int i = 0; i < 7; i++) begin
      wait_cycles(8);
      chk($sformatf("chase_step_%0d", i), 32'(bus.leds), 32'(chase_seq[i]));
    end
    wait_cycles(8);
    chk("chase_pos2", 32'(bus.leds), 32'h4);

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("async_rst_leds", 32'(bus.leds), 32'h0);
    chk("async_rst_mode", 32'(bus.mode), 32'd0);
    chk("async_rst_div",  32'(bus.speed_div), 32'd2);
    @(posedge clk);
    #1 rst = 1'b0;
    pulse(1, 0, 0);
    chk("post_rst_on", 32'(bus.leds), 32'hF);

    // Divisor saturation
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 1);
      chk($sformatf("down_%0d", i), 32'(bus.speed_div), (i == 0) ? 32'd3 : 32'd4);
    end
    for (int i = 0; i < 6; i++) begin
      pulse(0, 1, 0);
      chk($sformatf("up_%0d", i), 32'(bus.speed_div), (i < 3) ? 32'(3 - i) : 32'd1);
    end
    pulse(0, 1, 1);
    chk("up_down_same", 32'(bus.speed_div), 32'd1);
    pulse(0, 0, 1);
    chk("back_to_2", 32'(bus.speed_div), 32'd2);

    // Wrap CHASE -> OFF, then next together with down
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    chk("mode_chase_again", 32'(bus.mode), 32'd3);
    pulse(1, 0, 0);
    chk("wrap_off_mode", 32'(bus.mode), 32'd0);
    chk("wrap_off_leds", 32'(bus.leds), 32'h0);
    pulse(1, 0, 1);
    chk("next_down_mode", 32'(bus.mode), 32'd1);
    chk("next_down_leds", 32'(bus.leds), 32'hF);
    chk("next_down_div",  32'(bus.speed_div), 32'd3);

    wait_cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
